// File: rtl/adder_operand_ctrl.sv
// adder_operand_ctrl: sequences operand words into an external 4-bit adder and registers the sum.
// Defining ACCUM_MODE_EN turns it into an accumulator: one word per operation, op_a fed from the result.
module adder_operand_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] sum_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, LOAD_B, ADD, HOLD} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] b_q, b_d, res_q, res_d;
    logic             accept;
`ifndef ACCUM_MODE_EN
    logic [WIDTH-1:0] a_q, a_d;
`endif

    // reset gates in_ready directly so no word is offered a handshake while rst is high
    assign in_ready  = !rst && (state_q == IDLE || state_q == LOAD_B);
    assign accept    = in_valid && in_ready;
    assign out_valid = state_q == HOLD;
    assign out_data  = res_q;
    assign busy      = state_q != IDLE;
    assign op_b      = b_q;
`ifdef ACCUM_MODE_EN
    assign op_a      = res_q;
`else
    assign op_a      = a_q;
`endif

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        res_d   = res_q;
`ifndef ACCUM_MODE_EN
        a_d     = a_q;
`endif
        case (state_q)
            IDLE: if (accept) begin
`ifdef ACCUM_MODE_EN
                b_d     = in_data;
                state_d = ADD;
`else
                a_d     = in_data;
                state_d = LOAD_B;
`endif
            end
            LOAD_B: if (accept) begin
                b_d     = in_data;
                state_d = ADD;
            end
            ADD: begin
                res_d   = sum_in;
                state_d = HOLD;
            end
            default: if (out_ready) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            b_q     <= '0;
            res_q   <= '0;
`ifndef ACCUM_MODE_EN
            a_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            res_q   <= res_d;
`ifndef ACCUM_MODE_EN
            a_q     <= a_d;
`endif
        end
    end
endmodule

// File: tb/tb_adder_operand_ctrl.sv
// tb_adder_operand_ctrl: scoreboard bench; an ideal 4-bit adder closes the loop on op_a/op_b -> sum_in.
// Build with ACCUM_MODE_EN defined to exercise accumulate mode.
module tb_adder_operand_ctrl;
    logic       clk = 0;
    logic       rst = 1;
    logic       in_valid = 0;
    logic       in_ready;
    logic [3:0] in_data = 0;
    logic [3:0] op_a, op_b, sum_in, out_data;
    logic       out_valid, busy;
    logic       out_ready = 0;

    int errors = 0;
    int checks = 0;
    logic [3:0] exp_q[$];
    logic       have_a = 0;
    logic [3:0] a_w = 0;
    logic [3:0] acc = 0;
    logic       pv = 0, pr = 0;
    logic [3:0] pd = 0;

    adder_operand_ctrl #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .op_a(op_a), .op_b(op_b), .sum_in(sum_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy)
    );

    assign sum_in = 4'((int'(op_a) + int'(op_b)) % 16);

    always #5 clk = ~clk;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // reference: result of an operation is the modulo-16 sum of its words
    function automatic void accept_word(logic [3:0] w);
`ifdef ACCUM_MODE_EN
        acc = 4'((int'(acc) + int'(w)) % 16);
        exp_q.push_back(acc);
`else
        if (!have_a) begin
            a_w    = w;
            have_a = 1;
        end else begin
            exp_q.push_back(4'((int'(a_w) + int'(w)) % 16));
            have_a = 0;
        end
`endif
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            pv = 0;
        end else begin
            if (pv && !pr) begin
                check("stall_valid", int'(out_valid), 1);
                check("stall_data", int'(out_data), int'(pd));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %0d expected none at %0t", out_data, $time);
                end else begin
                    check("result", int'(out_data), int'(exp_q.pop_front()));
                end
            end
            pv = out_valid;
            pr = out_ready;
            pd = out_data;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        step();
        rst      = 1;
        in_valid = 0;
        step();
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_op_a", int'(op_a), 0);
        check("rst_op_b", int'(op_b), 0);
        check("rst_out_data", int'(out_data), 0);
        exp_q.delete();
        have_a = 0;
        acc    = 0;
        step();
        rst = 0;
        @(negedge clk);
        check("post_rst_in_ready", int'(in_ready), 1);
        step();
    endtask

    task automatic send(logic [3:0] w);
        int n = 0;
        in_valid = 1;
        in_data  = w;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_accepted", int'(in_ready), 1);
        accept_word(w);
        step();
        in_valid = 0;
    endtask

    task automatic wait_idle;
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 50);
        check("wait_idle", int'(busy), 0);
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
`ifdef ACCUM_MODE_EN
        out_ready = 1;
        send(4);
        wait_idle();
        send(5);
        wait_idle();
        send(9);
        wait_idle();
        check("accum_last", int'(out_data), 2);
`else
        // 3+5: result visible exactly two cycles after the B edge, for one cycle
        out_ready = 1;
        send(3);
        send(5);
        @(negedge clk);
        check("add_out_valid", int'(out_valid), 0);
        check("add_in_ready", int'(in_ready), 0);
        @(negedge clk);
        check("hold_out_valid", int'(out_valid), 1);
        check("hold_data_8", int'(out_data), 8);
        @(negedge clk);
        check("pulse_end", int'(out_valid), 0);
        check("back_idle", int'(busy), 0);
        step();

        send(9);
        send(9);
        wait_idle();
        check("wrap_9_9", int'(out_data), 2);

        // downstream stall
        out_ready = 0;
        send(6);
        send(4);
        @(negedge clk);
        check("stall_add_busy", int'(busy), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_ov", int'(out_valid), 1);
            check("stall_10", int'(out_data), 10);
            check("stall_in_ready", int'(in_ready), 0);
            check("stall_busy", int'(busy), 1);
        end
        step();
        out_ready = 1;
        @(negedge clk);
        @(negedge clk);
        check("idle_after_ready", int'(busy), 0);
        check("idle_in_ready", int'(in_ready), 1);
        step();

        // reset while waiting for B abandons the operation
        send(7);
        @(negedge clk);
        check("loadb_busy", int'(busy), 1);
        do_reset();
        send(1);
        send(2);
        wait_idle();
        check("after_abort", int'(out_data), 3);

        // in_valid held during ADD/HOLD must not be consumed
        out_ready = 0;
        send(2);
        send(3);
        in_valid = 1;
        in_data  = 15;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ignore_in_ready", int'(in_ready), 0);
            check("ignore_op_a", int'(op_a), 2);
            check("ignore_op_b", int'(op_b), 3);
        end
        step();
        out_ready = 1;
        @(negedge clk);
        @(negedge clk);
        check("first_idle_take", int'(in_ready), 1);
        accept_word(15);
        step();
        in_valid = 0;
        @(negedge clk);
        check("took_15", int'(op_a), 15);
        step();
        send(1);
        wait_idle();
        check("15_plus_1", int'(out_data), 0);
`endif
        // randomized traffic with random gaps and backpressure
        for (int k = 0; k < 40; k++) begin
            out_ready = 1'($urandom % 2);
            repeat ($urandom % 3) step();
            send(4'($urandom));
`ifndef ACCUM_MODE_EN
            repeat ($urandom % 3) step();
            send(4'($urandom));
`endif
            if (!out_ready) begin
                repeat ($urandom_range(1, 4)) step();
                out_ready = 1;
            end
            wait_idle();
        end
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/adder_operand_ctrl.md
ADDER_OPERAND_CTRL -- requirements
Module: adder_operand_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, operand/result width; only value 4 is supported, matching the 4-bit ripple adder.
REQ-002 The block SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1, upstream operand word present.
REQ-005 The block SHALL have port in_ready, output, 1, block accepts operand word this cycle.
REQ-006 The block SHALL have port in_data, input, 4, operand word.
REQ-007 The block SHALL have port op_a, output, 4, operand A to the 4-bit adder.
REQ-008 The block SHALL have port op_b, output, 4, operand B to the 4-bit adder.
REQ-009 The block SHALL have port sum_in, input, 4, combinational sum returned by the 4-bit adder (no carry-out).
REQ-010 The block SHALL have port out_valid, output, 1, result available.
REQ-011 The block SHALL have port out_ready, input, 1, downstream accepts result.
REQ-012 The block SHALL have port out_data, output, 4, registered result.
REQ-013 The block SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-014 The block SHALL implement a four-state FSM: IDLE, LOAD_B, ADD, HOLD.
REQ-015 IDLE: in_ready=1; on in_valid&in_ready, a_reg<=in_data, next LOAD_B; otherwise stay.
REQ-016 LOAD_B: in_ready=1; on in_valid&in_ready, b_reg<=in_data, next ADD; otherwise stay, a_reg held.
REQ-017 ADD: in_ready=0, exactly one cycle; res_reg<=sum_in at the closing edge, next HOLD.
REQ-018 HOLD: in_ready=0, out_valid=1, out_data=res_reg; on out_ready, next IDLE; otherwise stay.
REQ-019 op_a and op_b SHALL be driven directly from a_reg/b_reg at all times, never from in_data.
REQ-020 out_valid SHALL rise in the second cycle after the edge accepting B (one ADD cycle between).
REQ-021 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 Results SHALL be sum modulo 16; the carry is discarded and no overflow flag is produced.
REQ-023 in_valid in ADD or HOLD SHALL be ignored; no word is consumed.
REQ-024 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-025 rst high at a clock edge SHALL force state=IDLE, a_reg=b_reg=res_reg=0, and hence op_a=op_b=0, out_data=0, out_valid=0, busy=0.
REQ-026 in_ready SHALL be 0 in every cycle where rst=1, and 1 in the first cycle after reset deasserts.
REQ-027 Reset in any state SHALL abandon the operation in progress, with no out_valid pulse for it.

Configuration
REQ-028 Macro ACCUM_MODE_EN SHALL select accumulate mode when defined.
REQ-029 With ACCUM_MODE_EN defined: IDLE handshake loads b_reg and goes straight to ADD (LOAD_B unused); op_a is driven from res_reg; res_reg persists across operations and is cleared only by reset.
REQ-030 Without ACCUM_MODE_EN: two words per operation as in REQ-015..018, and res_reg does not feed op_a.

Verification
REQ-031 The bench SHALL cover: reset, A=3, B=5, out_ready=1 -> out_data=8, out_valid high for exactly one cycle, 2 cycles after the B edge.
REQ-032 The bench SHALL cover: A=9, B=9 -> out_data=2 (wrap, carry dropped).
REQ-033 The bench SHALL cover: A=6, B=4, out_ready held low 5 cycles -> out_data=10 stable, in_ready=0 and busy=1 throughout, and IDLE the cycle after out_ready rises.
REQ-034 The bench SHALL cover: A=7 accepted, rst pulsed in LOAD_B, then A=1, B=2 -> no result for 7, then out_data=3.
REQ-035 The bench SHALL cover: in_valid held high with data 15 during ADD/HOLD -> no extra word consumed, and the next operation takes the first word offered in IDLE.
REQ-036 The bench SHALL cover, with ACCUM_MODE_EN defined: words 4, 5, 9 after reset -> outputs 4, 9, 2 in order.
